// File: rtl/fetch_redirect_pkg.sv
// rtl/fetch_redirect_pkg.sv - shared fetch state encodings and constants
package fetch_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_if.sv
// rtl/fetch_redirect_if.sv - single-outstanding instruction memory req/gnt/rvalid bus
interface fetch_redirect_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_redirect_npc_sel.sv
// rtl/fetch_redirect_npc_sel.sv - next-PC mux (reset/redirect/trap/pc+4)
// MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_PC instead of being truncated.
module fetch_redirect_npc_sel
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic        rst,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] target,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        trap
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic misaligned;

  assign misaligned = (target[1:0] != 2'b00);
  assign trap       = TRAP_EN && redirect && misaligned;

  always_comb begin
    npc = pc;
    if (rst) begin
      npc = RESET_PC;
    end else if (trap) begin
      npc = TRAP_PC;
    end else if (redirect) begin
      npc = word_align(target);
    end else if (advance) begin
      npc = pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - fetch front end: PC, imem handshake, skid buffer, EX redirect/flush
// MISALIGN_TRAP_EN (in npc_sel) enables the misaligned-target trap and misalign pulse.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  logic                    ex_br,
  input  logic                    ex_jump,
  input  logic [31:0]             ex_target,
  input  logic                    stall,
  fetch_redirect_if.master        imem,
  output logic                    if_valid,
  output logic [31:0]             if_inst,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_pc4,
  output logic                    flush,
  output logic                    misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         skid_full_q, skid_full_d;
  logic [31:0]  skid_inst_q;
  logic         redirect, trap;
  logic         resp, take_resp, capture, release_skid, advance;

  assign redirect = ex_valid & (ex_br | ex_jump);

  // A full skid means nothing is in flight, so rvalid is only meaningful without it.
  assign resp         = (state_q == WAIT) && !skid_full_q && imem.rvalid;
  assign take_resp    = resp && !drop_q && !redirect && (!stall || !if_valid);
  assign capture      = resp && !drop_q && !redirect && stall && if_valid;
  assign release_skid = (state_q == WAIT) && skid_full_q && !redirect && !stall;
  assign advance      = take_resp | release_skid;

  assign imem.req  = (state_q == REQ);
  assign imem.addr = pc_q;

  fetch_redirect_npc_sel #(
    .RESET_PC (RESET_PC),
    .TRAP_PC  (TRAP_PC)
  ) u_npc_sel (
    .rst      (rst),
    .redirect (redirect),
    .advance  (advance),
    .target   (ex_target),
    .pc       (pc_q),
    .npc      (pc_d),
    .trap     (trap)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    skid_full_d = skid_full_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.gnt) begin
          state_d = WAIT;
          if (redirect) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (skid_full_q) begin
          if (redirect || !stall) begin
            state_d     = REQ;
            skid_full_d = 1'b0;
          end
        end else if (imem.rvalid) begin
          drop_d = 1'b0;
          if (capture) skid_full_d = 1'b1;
          else         state_d     = REQ;
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // npc_sel already folds reset into pc_d.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      skid_full_q <= 1'b0;
      skid_inst_q <= NOP_INST;
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= RESET_PC;
      if_pc4      <= RESET_PC + 32'd4;
      flush       <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      skid_full_q <= skid_full_d;
      flush       <= redirect;
      misalign    <= trap;
      if (capture) skid_inst_q <= imem.rdata;
      if (redirect) begin
        if_valid <= 1'b0;
      end else if (advance) begin
        if_valid <= 1'b1;
        if_inst  <= take_resp ? imem.rdata : skid_inst_q;
        if_pc    <= pc_q;
        if_pc4   <= pc_q + 32'd4;
      end else if (!stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - randomized bench for fetch_redirect against a transaction-level model
`timescale 1ns/1ps
module tb_fetch_redirect;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_br, ex_jump;
  logic [31:0] ex_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_inst, if_pc, if_pc4;
  logic        flush, misalign;

  fetch_redirect_if imem ();

  fetch_redirect #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_br(ex_br), .ex_jump(ex_jump),
    .ex_target(ex_target), .stall(stall), .imem(imem), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory side: one pending response at most
  bit          pending, pend_stale;
  logic [31:0] pend_addr;
  int          pend_delay;
  logic [31:0] gnt_log[$];

  // ID side expectations
  logic [31:0] exp_pc;
  int          kept, delivered, total_delivered, flush_seen, misal_seen;
  bit          last_rst, last_redir, last_misal, last_held, last_req_wait;
  logic [31:0] last_addr, last_pc, last_inst, first_fresh_pc, first_fresh_inst, last_fresh_pc;

  // Stimulus knobs
  int          rst_cnt, rv_delay_max, stall_mode;
  bit          force_gnt, rand_redir, spur_en, os_redir, os_jump;
  logic [31:0] os_tgt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] redirect_pc(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) return TRP_PC;
`endif
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic sample_checks();
    if (last_rst) begin
      check_eq("rst_req", imem.req, 0);
      check_eq("rst_if_valid", if_valid, 0);
      check_eq("rst_flush", flush, 0);
      check_eq("rst_misalign", misalign, 0);
      check_eq("rst_if_inst", if_inst, NOP);
      check_eq("rst_if_pc", if_pc, RST_PC);
      check_eq("rst_if_pc4", if_pc4, RST_PC + 32'd4);
      return;
    end
    if (flush) flush_seen++;
    if (misalign) misal_seen++;
    check_eq("flush", flush, last_redir);
    check_eq("misalign", misalign, last_misal);
    if (last_redir) begin
      check_eq("valid_after_redirect", if_valid, 0);
    end else if (last_held) begin
      check_eq("hold_valid", if_valid, 1);
      check_eq("hold_pc", if_pc, last_pc);
      check_eq("hold_inst", if_inst, last_inst);
    end else if (if_valid) begin
      check_eq("fetch_pc", if_pc, exp_pc);
      check_eq("fetch_inst", if_inst, mem_word(exp_pc));
      check_eq("fetch_pc4", if_pc4, exp_pc + 32'd4);
      if (delivered == 0) begin
        first_fresh_pc   = if_pc;
        first_fresh_inst = if_inst;
      end
      last_fresh_pc = if_pc;
      exp_pc        = exp_pc + 32'd4;
      delivered++;
      total_delivered++;
    end
    if (pending) check_eq("single_outstanding", imem.req, 0);
    if (last_req_wait) check_eq("addr_stable", imem.addr, last_addr);
    check_eq("skid_depth", (kept - delivered) <= 1, 1);
    if (kept - delivered == 1) check_eq("no_req_skid_full", imem.req, 0);
  endtask

  task automatic update_model();
    bit redir, resp, grant;
    redir = ex_valid && (ex_br || ex_jump);
    if (rst) begin
      pending = 0; exp_pc = RST_PC; kept = 0; delivered = 0;
      last_rst = 1; last_redir = 0; last_misal = 0; last_held = 0; last_req_wait = 0;
      return;
    end
    last_rst = 0;
    resp  = imem.rvalid && pending;
    grant = imem.req && imem.gnt;
    if (resp) begin
      if (!pend_stale && !redir) kept++;
      pending = 0;
    end else if (pending && redir) begin
      pend_stale = 1;
    end
    if (grant) begin
      pending    = 1;
      pend_addr  = imem.addr;
      pend_stale = redir;
      pend_delay = $urandom_range(0, rv_delay_max);
      if (!redir) gnt_log.push_back(imem.addr);
    end
    last_held     = !redir && stall && if_valid;
    last_req_wait = imem.req && !imem.gnt && !redir;
    last_addr     = imem.addr;
    last_pc       = if_pc;
    last_inst     = if_inst;
    last_redir    = redir;
`ifdef MISALIGN_TRAP_EN
    last_misal    = redir && (ex_target[1:0] != 2'b00);
`else
    last_misal    = 0;
`endif
    if (redir) begin
      exp_pc    = redirect_pc(ex_target);
      kept      = 0;
      delivered = 0;
    end
  endtask

  task automatic drive();
    if (rst_cnt > 0) begin rst = 1; rst_cnt--; end
    else rst = 0;
    case (stall_mode)
      0:       stall = 0;
      1:       stall = 1;
      default: stall = ($urandom_range(0, 2) == 0);
    endcase
    ex_valid = 0; ex_br = 0; ex_jump = 0; ex_target = $urandom;
    if (os_redir) begin
      ex_valid = 1; ex_br = !os_jump; ex_jump = os_jump; ex_target = os_tgt;
      os_redir = 0;
    end else if (rand_redir) begin
      case ($urandom_range(0, 15))
        0: begin ex_valid = 1; ex_br = 1; end
        1: begin ex_valid = 1; ex_jump = 1; end
        2: ex_valid = 1;
        3: begin ex_br = 1; ex_jump = 1; end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ex_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    end
    imem.gnt    = imem.req && (force_gnt || $urandom_range(0, 2) != 0);
    imem.rvalid = 0;
    imem.rdata  = $urandom;
    if (pending) begin
      if (pend_delay == 0) begin
        imem.rvalid = 1;
        imem.rdata  = mem_word(pend_addr);
      end else begin
        pend_delay--;
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      imem.rvalid = 1;
    end
    update_model();
  endtask

  task automatic step();
    @(negedge clk);
    sample_checks();
    drive();
  endtask

  task automatic step_until_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 40) begin step(); n++; end
    check_eq(tag, if_valid, 1);
  endtask

  task automatic redirect_next(input logic [31:0] tgt, input bit jump);
    gnt_log.delete();
    flush_seen = 0; misal_seen = 0;
    os_tgt = tgt; os_jump = jump; os_redir = 1;
  endtask

  initial begin
    int n;
    logic [31:0] hold_pc;
    rst = 1; stall = 0; ex_valid = 0; ex_br = 0; ex_jump = 0; ex_target = 0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
    pending = 0; pend_stale = 0; pend_addr = 0; pend_delay = 0;
    exp_pc = RST_PC; kept = 0; delivered = 0; total_delivered = 0;
    flush_seen = 0; misal_seen = 0;
    last_rst = 1; last_redir = 0; last_misal = 0; last_held = 0; last_req_wait = 0;
    last_addr = 0; last_pc = 0; last_inst = 0;
    first_fresh_pc = 32'hDEAD_BEEF; first_fresh_inst = 0; last_fresh_pc = 0;
    rst_cnt = 2; rv_delay_max = 0; stall_mode = 0;
    force_gnt = 1; rand_redir = 0; spur_en = 0; os_redir = 0; os_jump = 0; os_tgt = 0;

    // Boot: gnt always, rvalid one cycle after gnt
    repeat (12) step();
    check_eq("boot_addr0", log_at(0), 32'h0);
    check_eq("boot_addr1", log_at(1), 32'h4);
    check_eq("boot_addr2", log_at(2), 32'h8);
    check_eq("boot_first_pc", first_fresh_pc, 32'h0);
    check_eq("boot_first_inst", first_fresh_inst, 32'h0010_0093);

    // Stall hold: skid fills, request stops, release delivers the next word
    step_until_valid("stall_wait_valid");
    stall_mode = 1;
    repeat (5) step();
    check_eq("stall_req_idle", imem.req, 0);
    check_eq("stall_valid_held", if_valid, 1);
    hold_pc = last_fresh_pc;
    stall_mode = 0;
    repeat (2) step();
    check_eq("stall_release_pc", last_fresh_pc, hold_pc + 32'd4);

    // Redirect while a response is outstanding
    rv_delay_max = 3;
    n = 0;
    do begin step(); n++; end while (!(pending && pend_delay >= 1) && n < 50);
    check_eq("wait_found_pending", pending && pend_delay >= 1, 1);
    redirect_next(32'h0000_0040, 0);
    repeat (20) step();
    check_eq("redir_wait_addr", log_at(0), 32'h40);
    check_eq("redir_wait_pc", first_fresh_pc, 32'h40);
    check_eq("redir_wait_flush_once", flush_seen, 1);

    // Redirect while stalled
    rv_delay_max = 0;
    step_until_valid("rs_wait_valid");
    stall_mode = 1;
    redirect_next(32'h0000_0080, 1);
    repeat (2) step();
    check_eq("rs_flush", flush, 1);
    check_eq("rs_valid_low", if_valid, 0);
    stall_mode = 0;
    step_until_valid("rs_resume_valid");
    check_eq("rs_resume_pc", first_fresh_pc, 32'h80);

    // PC wrap
    redirect_next(32'hFFFF_FFF8, 1);
    repeat (12) step();
    check_eq("wrap_addr0", log_at(0), 32'hFFFF_FFF8);
    check_eq("wrap_addr1", log_at(1), 32'hFFFF_FFFC);
    check_eq("wrap_addr2", log_at(2), 32'h0000_0000);

    // Misaligned jump target
    redirect_next(32'h0000_0042, 1);
    repeat (8) step();
`ifdef MISALIGN_TRAP_EN
    check_eq("misal_addr", log_at(0), TRP_PC);
    check_eq("misal_pulses", misal_seen, 1);
`else
    check_eq("misal_addr", log_at(0), 32'h40);
    check_eq("misal_pulses", misal_seen, 0);
`endif

    // Reset mid-transaction; stray rvalids afterwards must be ignored
    rv_delay_max = 3; spur_en = 1;
    n = 0;
    do begin step(); n++; end while (!pending && n < 50);
    check_eq("mid_rst_pending", pending, 1);
    rst_cnt = 1;
    repeat (14) step();
    check_eq("mid_rst_first_pc", first_fresh_pc, RST_PC);

    // Fully randomized traffic
    force_gnt = 0; rv_delay_max = 4; stall_mode = 2; rand_redir = 1;
    repeat (3000) step();
    rand_redir = 0; stall_mode = 0;
    repeat (20) step();
    check_eq("progress", total_delivered > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Instruction-fetch front end that consumes EX stage resolution (branch flag f, target from ALU result C).
- Owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to ID and flushes the younger pipeline contents on a taken redirect.
- Sits between instruction memory and the IF/ID boundary.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned target (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  EX holds a resolved control-flow instruction this cycle.
- ex_br  in  1  branch-taken flag from EX branch unit.
- ex_jump  in  1  unconditional jump (jal/jalr).
- ex_target  in  32  redirect target (EX ALU result).
- stall  in  1  hazard unit: ID cannot accept.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_inst/if_pc valid to ID.
- if_inst  out  32  fetched instruction.
- if_pc  out  32  address of if_inst.
- if_pc4  out  32  if_pc + 4.
- flush  out  1  one-cycle pulse: kill ID/EX contents.
- misalign  out  1  one-cycle misaligned-target pulse (0 without feature).

Behaviour:
- Reset values:
  - Outputs: imem_req=0, if_valid=0, flush=0, misalign=0; if_inst=32'h0000_0013 (nop), if_pc=RESET_PC, if_pc4=RESET_PC+4.
  - Internal: pc=RESET_PC, drop=0, state=IDLE.
- States: IDLE, REQ, WAIT. Only one request outstanding.
- IDLE: entered only from reset; next cycle moves to REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT; otherwise hold address and remain in REQ.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=1: discard data, clear drop, go to REQ.
  - drop=0 and (stall=0 or if_valid=0): register rdata into if_inst; if_pc=pc; if_pc4=pc+4; if_valid=1 the next cycle; pc<=pc+4; go to REQ.
  - drop=0 and stall=1 with if_valid=1: keep the data in a one-entry skid register and issue no new request. Move it to the outputs on the first cycle stall=0, then go to REQ.
- Stall: while stall=1, if_valid/if_inst/if_pc stay frozen. if_valid drops to 0 when ID accepts (stall=0) and no new word is ready.
- Fetch latency: first if_valid at least 3 cycles after rst deasserts (IDLE, REQ with gnt, rvalid).
- Redirect: redirect = ex_valid & (ex_br | ex_jump).
  - Highest priority, ignores stall.
  - Next cycle: pc<=target; flush=1 for exactly one cycle; if_valid=0; skid cleared.
  - Redirect in WAIT, or coinciding with gnt in REQ: drop<=1 so the in-flight response is discarded.
  - Redirect in REQ without gnt: imem_addr switches to the target next cycle (permitted exception to address stability).
  - Redirect coinciding with rvalid: data discarded, go to REQ at target.
- Target alignment: ex_target[1:0] forced to 2'b00.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- rvalid outside WAIT is ignored.
- rst mid-transaction: returns to the reset values above; any later rvalid is ignored because state is not WAIT.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a redirect with ex_target[1:0]!=0 loads pc<=TRAP_PC instead of the target. misalign=1 and flush=1 for one cycle; drop rules apply as for a normal redirect.
- Undefined: low bits are forced to zero, misalign is tied to 0, TRAP_PC is unused.

Decomposition:
- Shared defines package holds:
  - Fetch state encodings (IDLE/REQ/WAIT).
  - NOP encoding 32'h0000_0013.
  - Default RESET_PC.
- One natural sub-module, npc_sel: combinational next-PC mux (reset/redirect/trap/pc+4) with alignment handling.

Test Plan:
- Reset boot: rst high 2 cycles then low; gnt=1, rvalid 1 cycle after gnt with rdata=32'h0010_0093 → imem_addr=0, then 4, 8; if_inst=32'h0010_0093 with if_pc=0.
- Stall hold: stall=1 for 5 cycles after if_valid rises → if_inst/if_pc frozen, at most one word skidded, no req issued while skid full; stall release delivers the skidded word at if_pc+4.
- Redirect in WAIT: ex_valid=1, ex_br=1, ex_target=32'h0000_0040 while awaiting rvalid → flush pulse 1 cycle; stale rdata dropped; next imem_addr=32'h40; next if_pc=32'h40.
- Redirect vs stall: redirect with stall=1 → flush=1, if_valid=0 next cycle, fetch resumes at target.
- Wrap: pc=32'hFFFF_FFFC fetched → next imem_addr=32'h0000_0000.
- MISALIGN_TRAP_EN: ex_jump=1, ex_target=32'h0000_0042 → misalign=1 for one cycle, next imem_addr=TRAP_PC=32'h100. With the macro off: next imem_addr=32'h40, misalign=0.
